// File: rtl/fieldstore_ctl.sv
// fieldstore_ctl
// Sequencer for MIX partial-field stores (STA/STX/ST1-6/STJ/STZ). One store
// command is accepted from the control unit. The block then owns the memory
// port until the command finishes. It reads the target word, merges the
// rightmost register bytes into field (L:R), and writes the merged word back.
// A full-word field (0:5) skips the read. An invalid field (L>R or R>5) ends
// the command with an error and makes no memory access.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             command strobe, sampled only in IDLE
//   addr/reg_in/field command operands, latched on an accepted start
//   busy              high from the cycle after start through DONE
//   done, err         one-cycle completion pulse; err marks an invalid field
//   mem_*             memory request port
//   dbg_state         current sequencer state, for observation only
//
// Memory handshake: mem_req stays high, with mem_we/mem_addr/mem_wdata
// stable, until the first cycle in which mem_ack=1 is sampled. That edge
// completes the transfer. mem_req is low in the following cycle. mem_ack is
// ignored whenever no request is outstanding.
module fieldstore_ctl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [30:0]       reg_in,
  input  logic [5:0]        field,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [30:0]       mem_wdata,
  input  logic [30:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHK   = 3'd1,
    RD    = 3'd2,
    MERGE = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [30:0]       wdata_q, wdata_d;
  logic [30:0]       reg_q, reg_d;
  logic [5:0]        field_q, field_d;
  logic [30:0]       rdata_q, rdata_d;
  logic              field_bad;

  // Byte k (k=1..5) sits at bits [35-6k:30-6k]; the sign is bit 30.
  // Field bytes [max(L,1)..R] take the rightmost register bytes, so byte k
  // takes register byte k+5-R. The sign changes only when L=0.
  function automatic logic [30:0] merge_word(input logic [30:0] m,
                                             input logic [30:0] r,
                                             input logic [2:0]  l,
                                             input logic [2:0]  rr);
    logic [30:0] res;
    int          lp;
    int          rp;
    int          j;
    res = m;
    rp  = int'(rr);
    lp  = (l == 3'd0) ? 1 : int'(l);
    if (l == 3'd0) res[30] = r[30];
    for (int k = 1; k <= 5; k++) begin
      if (k >= lp && k <= rp) begin
        j = k + 5 - rp;
        res[30-6*k +: 6] = r[30-6*j +: 6];
      end
    end
    return res;
  endfunction

  assign field_bad = (field_q[5:3] > field_q[2:0]) || (field_q[2:0] > 3'd5);

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    reg_d   = reg_q;
    field_d = field_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = addr;
          reg_d   = reg_in;
          field_d = field;
          busy_d  = 1'b1;
          state_d = CHK;
        end
      end
      CHK: begin
        if (field_bad) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (field_q == 6'd5) begin
          // Whole word replaced: no read needed.
          wdata_d = reg_q;
          req_d   = 1'b1;
          we_d    = 1'b1;
          state_d = WR;
        end else begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          state_d = RD;
        end
      end
      RD: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          req_d   = 1'b0;
          state_d = MERGE;
        end
      end
      MERGE: begin
        wdata_d = merge_word(rdata_q, reg_q, field_q[5:3], field_q[2:0]);
        req_d   = 1'b1;
        we_d    = 1'b1;
        state_d = WR;
      end
      WR: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        req_d   = 1'b0;
        we_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      reg_q   <= '0;
      field_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      reg_q   <= reg_d;
      field_q <= field_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dbg_state = state_q;

endmodule
